// File: rtl/operator_pkg.sv
// Shared definitions for the operator controller and the display block:
// operator codes, FSM state encoding and the default operand width.
package operator_pkg;

    localparam int W_DEFAULT = 5;

    typedef logic [2:0] op_t;

    localparam op_t OP_ADD  = 3'd0;
    localparam op_t OP_SUB  = 3'd1;
    localparam op_t OP_AND  = 3'd2;
    localparam op_t OP_OR   = 3'd3;
    localparam op_t OP_MUL  = 3'd4;
    localparam op_t OP_LAST = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Operator stepping wraps after the last code so choose never leaves 0..4.
    function automatic op_t next_op(input op_t op);
        return (op == OP_LAST) ? OP_ADD : op + 3'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a
// one-cycle pulse on each accepted press (releases are accepted silently).
module btn_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pulse
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle where the synced level agrees with the accepted one restarts the count.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        pulse_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                pulse_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/operator_ctrl.sv
// Control/datapath stage feeding the operator display: debounced operator
// stepping, operand latching and a single-cycle ALU plus shift-add multiplier.
module operator_ctrl
    import operator_pkg::*;
#(
    parameter int DB_CYCLES = 1000000,
    parameter int W         = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn_op,
    input  logic         btn_go,
    input  logic [W-1:0] sw_a,
    input  logic [W-1:0] sw_b,
    output logic [2:0]   choose,
    output logic         EN,
    output logic [W-1:0] f,
    output logic [W-1:0] result,
    output logic         busy
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic op_p;
    logic go_p;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_op (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_op),
        .pulse   (op_p)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_go (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_go),
        .pulse   (go_p)
    );

    state_t          state_q, state_d;
    op_t             choose_q, choose_d;
    logic            en_q, en_d;
    logic            busy_q, busy_d;
    logic [W-1:0]    a_s1_q, a_s1_d, a_s2_q, a_s2_d;
    logic [W-1:0]    b_s1_q, b_s1_d, b_s2_q, b_s2_d;
    logic [W-1:0]    opa_q, opa_d;
    logic [W-1:0]    opb_q, opb_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    result_q, result_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    mul_sum;

    // The multiplier consumes opa/opb in place: opa shifts left, opb shifts right.
    always_comb begin
        a_s1_d   = sw_a;
        a_s2_d   = a_s1_q;
        b_s1_d   = sw_b;
        b_s2_d   = b_s1_q;
        state_d  = state_q;
        choose_d = choose_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        mul_sum  = acc_q + (opb_q[0] ? opa_q : '0);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (go_p) begin
                    opa_d   = a_s2_q;
                    opb_d   = b_s2_q;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end else if (op_p) begin
                    choose_d = next_op(choose_q);
                    state_d  = ST_IDLE;
                end
            end
            ST_CALC: begin
                case (choose_q)
                    OP_ADD: begin
                        result_d = opa_q + opb_q;
                        state_d  = ST_DONE;
                    end
                    OP_SUB: begin
                        result_d = opa_q - opb_q;
                        state_d  = ST_DONE;
                    end
                    OP_AND: begin
                        result_d = opa_q & opb_q;
                        state_d  = ST_DONE;
                    end
                    OP_OR: begin
                        result_d = opa_q | opb_q;
                        state_d  = ST_DONE;
                    end
                    OP_MUL: begin
                        acc_d = mul_sum;
                        opa_d = opa_q << 1;
                        opb_d = opb_q >> 1;
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q == MUL_LAST) begin
                            result_d = mul_sum;
                            state_d  = ST_DONE;
                        end
                    end
                    default: state_d = ST_DONE;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase

        en_d   = (state_d == ST_DONE);
        busy_d = (state_d == ST_CALC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            choose_q <= OP_ADD;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            a_s1_q   <= '0;
            a_s2_q   <= '0;
            b_s1_q   <= '0;
            b_s2_q   <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            choose_q <= choose_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            a_s1_q   <= a_s1_d;
            a_s2_q   <= a_s2_d;
            b_s1_q   <= b_s1_d;
            b_s2_q   <= b_s2_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign choose = choose_q;
    assign EN     = en_q;
    assign f      = a_s2_q;
    assign result = result_q;
    assign busy   = busy_q;

endmodule

// File: doc/operator_ctrl.md
Name: operator_ctrl

Overview:
- Sequential control and datapath stage directly upstream of the operator display block.
- Debounces two push-buttons, steps through five operators, latches two 5-bit switch operands and computes a 5-bit result (MUL is multi-cycle).
- Drives the display's choose, EN, f and result inputs.

Parameters:
- DB_CYCLES, 1000000, cycles a synchronized button level must stay stable before it is accepted (10 ms at 100 MHz).
- W, 5, operand/result width (display fixes 5).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- btn_op  input  1  raw button: step to next operator
- btn_go  input  1  raw button: execute current operator
- sw_a  input  W  raw operand A switches
- sw_b  input  W  raw operand B switches
- choose  output  3  operator code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL
- EN  output  1  1 = result valid (display shows result), 0 = display shows f
- f  output  W  registered, synchronized copy of sw_a (live operand preview)
- result  output  W  latched result
- busy  output  1  high while computing

Behaviour:
- Interface: one clock, clk; rst is synchronous and active-high.
- Reset (rst=1 at an edge): choose=0, EN=0, f=0, result=0, busy=0, state IDLE, all debouncer and MUL registers 0. rst mid-CALC aborts with no partial result.
- sw_a/sw_b pass through a 2-FF synchronizer. f is the synchronizer output and updates every cycle in all states.
- Debounce per button:
  - counter increments while the synced level differs from the accepted level, clears otherwise.
  - At count DB_CYCLES-1 the accepted level flips.
  - An accepted 0->1 flip emits a 1-cycle pulse (op_p / go_p).
  - Release is accepted silently.
- FSM states: IDLE, CALC, DONE.
- IDLE (EN=0, busy=0):
  - go_p -> latch a,b from the synchronizer; enter CALC.
  - op_p alone -> choose = (choose==4) ? 0 : choose+1.
  - go_p and op_p in the same cycle -> go wins; op_p dropped, choose unchanged.
- CALC (busy=1, EN=0): op_p and go_p ignored.
  - ADD/SUB/AND/OR: result registered at the first edge in CALC; next state DONE.
  - MUL: shift-add over W=5 iterations, counter 0..4, one iteration per edge; result written on the 5th edge; then DONE.
- DONE (EN=1, busy=0): result held.
  - op_p -> EN=0, choose advances (same wrap), state IDLE.
  - go_p -> re-latch a,b, EN=0, CALC.
  - Both in the same cycle -> go wins.
- Latency, counted from the edge at which go_p is sampled (edge k):
  - single-cycle ops: EN=1 and result valid after edge k+1.
  - MUL: EN=1 and result valid after edge k+5.
- Arithmetic is modulo 2^W:
  - ADD: truncated sum.
  - SUB: a-b with two's-complement wrap.
  - MUL: low W bits of the product.
  - AND/OR: bitwise.
- choose is never outside 0..4.
- choose and EN change only on edges and are glitch-free, registered outputs.

Decomposition:
- Shared package operator_pkg:
  - op codes OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_MUL=4, OP_LAST=4.
  - state encoding (IDLE, CALC, DONE).
  - W default.
  - The display block also uses the op codes.
- One sub-module, btn_debounce (param DB_CYCLES; ports clk, rst, btn_raw, pulse), instantiated twice.
- FSM and datapath stay in operator_ctrl.

Test Plan (DB_CYCLES=4):
- Reset, then 7 clean op presses -> choose steps 1,2,3,4,0,1,2; EN stays 0. A press bouncing for 2 cycles -> no pulse.
- choose=0, sw_a=19, sw_b=20, go -> busy for 1 cycle, then EN=1, result=7 (39 mod 32). Then choose=1, sw_a=3, sw_b=5, go -> result=30.
- choose=4, sw_a=7, sw_b=6, go -> busy exactly 5 cycles, EN=1, result=10. op/go pulses injected during busy are ignored and choose stays 4.
- In DONE, op press -> EN=0, choose advances; f tracks sw_a changes (sw_a=21 -> f=21 after 2 cycles). op and go pulses forced in the same cycle -> computation starts, choose unchanged.
- rst asserted on the 3rd MUL cycle -> next cycle: busy=0, EN=0, result=0, choose=0, state IDLE. A following go computes ADD correctly.
